// File: rtl/ff_bank_load_arbiter.sv
// Round-robin load controller for a shared enable register: picks one requester,
// loads its word, pulses its grant, then holds the value for HOLD_CYC cycles.
module ff_bank_load_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2,
  parameter int OWNER_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_ah_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   clr_in,
  input  logic                   set_in,
  output logic [WIDTH-1:0]       q_out,
  output logic                   valid_out,
  output logic [N_REQ-1:0]       grant_out,
  output logic [OWNER_W-1:0]     owner_out,
  output logic                   busy_out
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               valid_q, valid_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;

  logic               win_found;
  logic [OWNER_W-1:0] win_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [WIDTH-1:0]   win_data;
  logic [WIDTH-1:0]   data_word [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_word[gi]  = data_in[gi*WIDTH +: WIDTH];
      assign win_onehot[gi] = win_found && (win_idx == OWNER_W'(gi));
    end
  endgenerate

  assign win_data = data_word[win_idx];

  // First asserted request at or after ptr, wrapping past the top index.
  always_comb begin : search
    logic [OWNER_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = OWNER_W'((int'(ptr_q) + off) % N_REQ);
      if (!win_found && req_in[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = valid_q;
    grant_d = '0;
    owner_d = owner_q;

    if (clr_in) begin
      q_d     = '0;
      valid_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (set_in) begin
      q_d     = '1;
      valid_d = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            q_d     = win_data;
            grant_d = win_onehot;
            owner_d = win_idx;
            valid_d = 1'b1;
            ptr_d   = (win_idx == OWNER_W'(N_REQ - 1)) ? '0 : win_idx + OWNER_W'(1);
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_CYC - 1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
    end
  end

  assign q_out     = q_q;
  assign valid_out = valid_q;
  assign grant_out = grant_q;
  assign owner_out = owner_q;
  assign busy_out  = (state_q == HOLD);

endmodule

// File: tb/tb_ff_bank_load_arbiter.sv
// Directed bench for ff_bank_load_arbiter (N_REQ=4, WIDTH=8, HOLD_CYC=2).
module tb_ff_bank_load_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        clr;
  logic        set;
  logic [7:0]  q;
  logic        valid;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;

  logic [7:0]  d [4];
  int          checks;
  int          errors;

  logic [3:0]  rr_grant [5];
  logic [7:0]  rr_q     [5];
  logic [1:0]  rr_owner [5];

  assign data = {d[3], d[2], d[1], d[0]};

  ff_bank_load_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYC(2)) dut (
    .clk(clk), .reset_ah_in(rst), .req_in(req), .data_in(data),
    .clr_in(clr), .set_in(set), .q_out(q), .valid_out(valid),
    .grant_out(grant), .owner_out(owner), .busy_out(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; req = 4'b0000; clr = 1'b0; set = 1'b0;
    d[0] = 8'h11; d[1] = 8'hA5; d[2] = 8'h33; d[3] = 8'h44;
    rr_grant[0] = 4'b0001; rr_grant[1] = 4'b0010; rr_grant[2] = 4'b0100;
    rr_grant[3] = 4'b1000; rr_grant[4] = 4'b0001;
    rr_q[0] = 8'h11; rr_q[1] = 8'hA5; rr_q[2] = 8'h33; rr_q[3] = 8'h44; rr_q[4] = 8'h11;
    rr_owner[0] = 2'd0; rr_owner[1] = 2'd1; rr_owner[2] = 2'd2;
    rr_owner[3] = 2'd3; rr_owner[4] = 2'd0;

    // Power-up reset, asserted between edges
    #1 rst = 1'b1;
    #2;
    chk("rst_q", q, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    chk("rst_busy", busy, 1'b0);
    tick;
    rst = 1'b0;

    // Single load from requester 1
    req = 4'b0010;
    tick;
    chk("single_q", q, 8'hA5);
    chk("single_grant", grant, 4'b0010);
    chk("single_owner", owner, 2'd1);
    chk("single_valid", valid, 1'b1);
    chk("single_busy0", busy, 1'b1);
    req = 4'b0000;
    d[1] = 8'h5A;
    tick;
    chk("single_grant_end", grant, 4'b0000);
    chk("single_busy1", busy, 1'b1);
    chk("single_q_held", q, 8'hA5);
    tick;
    chk("single_busy_low", busy, 1'b0);
    chk("single_valid_kept", valid, 1'b1);
    d[1] = 8'hA5;

    // Load 0x3C, then asynchronous reset mid-cycle
    d[3] = 8'h3C;
    req  = 4'b1000;
    tick;
    chk("pre_rst_q", q, 8'h3C);
    chk("pre_rst_grant", grant, 4'b1000);
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_valid", valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_grant", grant, 4'b0000);
    chk("arst_owner", owner, 2'd0);
    #1 rst = 1'b0;
    d[3] = 8'h44;

    // Round robin with all requesters asserted from reset
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_grant", grant, rr_grant[i]);
      chk("rr_q", q, rr_q[i]);
      chk("rr_owner", owner, rr_owner[i]);
      tick;
      chk("rr_gap1_grant", grant, 4'b0000);
      chk("rr_gap1_busy", busy, 1'b1);
      tick;
      chk("rr_gap2_grant", grant, 4'b0000);
      chk("rr_gap2_busy", busy, 1'b0);
    end

    // Wrap and skip: ptr=1 -> grant 2 -> ptr=3; req 0001 wraps to 0
    req = 4'b0100;
    tick;
    chk("wrap_g2", grant, 4'b0100);
    req = 4'b0001;
    tick;
    chk("wrap_hold_ignore1", grant, 4'b0000);
    tick;
    chk("wrap_hold_ignore2", grant, 4'b0000);
    tick;
    chk("wrap_g0", grant, 4'b0001);
    chk("wrap_owner0", owner, 2'd0);
    req = 4'b0011;
    tick;
    tick;
    tick;
    chk("wrap_ptr1_grant", grant, 4'b0010);
    req = 4'b0000;
    tick;
    tick;

    // Clear one cycle after a load of 0x77, with a pending request
    d[2] = 8'h77;
    req  = 4'b0100;
    tick;
    chk("clr_load_q", q, 8'h77);
    chk("clr_load_grant", grant, 4'b0100);
    clr = 1'b1;
    req = 4'b0001;
    tick;
    chk("clr_q", q, 8'h00);
    chk("clr_valid", valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_grant", grant, 4'b0000);
    clr = 1'b0;
    tick;
    chk("clr_pending_grant", grant, 4'b0001);
    chk("clr_pending_q", q, 8'h11);
    req = 4'b0000;
    tick;
    tick;
    chk("clr_idle", busy, 1'b0);

    // Set beats request; clear beats set
    set = 1'b1;
    req = 4'b0100;
    tick;
    chk("set_q", q, 8'hFF);
    chk("set_valid", valid, 1'b1);
    chk("set_grant", grant, 4'b0000);
    chk("set_owner", owner, 2'd0);
    chk("set_busy", busy, 1'b0);
    clr = 1'b1;
    tick;
    chk("clrset_q", q, 8'h00);
    chk("clrset_valid", valid, 1'b0);
    chk("clrset_grant", grant, 4'b0000);
    clr = 1'b0;
    set = 1'b0;
    tick;
    chk("after_set_grant", grant, 4'b0100);
    chk("after_set_owner", owner, 2'd2);
    chk("after_set_q", q, 8'h77);
    req = 4'b0000;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_bank_load_arbiter.md
# ff_bank_load_arbiter

Round-robin load controller for a shared WIDTH-bit enable register. N_REQ requesters compete to load their data word into the register. The block arbitrates between them, drives the register's load, and returns a one-cycle grant to the winner. After each load the value is held for HOLD_CYC cycles so downstream logic can consume it. Synchronous clear/set controls keep the clear-over-set-over-load priority the team uses for its enable flip-flops.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register width
- HOLD_CYC, 2, cycles the loaded value is held before re-arbitration (>=1)
- OWNER_W, max(1, clog2(N_REQ)), owner index width (derived)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_ah_in  in  1  reset, asynchronous, active-high
- req_in  in  N_REQ  request per requester; held until its grant pulse is seen
- data_in  in  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- clr_in  in  1  synchronous clear of register
- set_in  in  1  synchronous set of register to all ones
- q_out  out  WIDTH  shared register value
- valid_out  out  1  q_out holds a loaded or set value
- grant_out  out  N_REQ  one-hot, one-cycle pulse to the requester whose data was loaded
- owner_out  out  OWNER_W  index of the last granted requester
- busy_out  out  1  high in HOLD state

## Operation
- States: IDLE, HOLD. Internal state: rotating pointer ptr (OWNER_W bits) and hold counter cnt.
- Priority each cycle, in any state: clr_in, then set_in, then arbitration.
- clr_in=1: q<=0, valid<=0, grant<=0, state<=IDLE, cnt<=0. ptr and owner are unchanged.
- clr_in=0, set_in=1: q<=all ones, valid<=1, grant<=0, state<=IDLE, cnt<=0. ptr and owner are unchanged.
- IDLE, no clr/set, no req: all registers hold; grant<=0.
- IDLE, no clr/set, any req:
  - Winner w = first asserted req searching from index ptr upward, wrapping N_REQ-1 -> 0.
  - At the edge: q<=data_in[w], grant<=one-hot(w), owner<=w, valid<=1, ptr<=(w+1) mod N_REQ, state<=HOLD, cnt<=HOLD_CYC-1.
- HOLD, no clr/set: req_in is ignored and grant<=0.
  - If cnt==0: state<=IDLE.
  - Otherwise: cnt<=cnt-1.
- Withdrawal: a requester that drops req before its grant is skipped. No error is raised.
- busy_out = (state==HOLD). This output is combinational from the state register.

## Timing
- Reset values: q_out=0, valid_out=0, grant_out=0, owner_out=0, busy_out=0. Internal: ptr=0, cnt=0, state=IDLE. Outputs take these values immediately on reset assertion, independent of clk.
- Grant latency: req sampled in an IDLE cycle at edge k. q_out, grant_out and owner_out all update at edge k. The grant pulse lasts exactly one cycle, ending at edge k+1.
- HOLD lasts exactly HOLD_CYC cycles. Maximum load rate is one per HOLD_CYC+1 cycles. With HOLD_CYC=2, continuous requests give grants every 3 cycles.
- Fairness: with all requesters asserted continuously, each is granted once in every N_REQ grants.
- Reset mid-HOLD: the block returns to IDLE and the held value is lost. No grant is issued for the aborted cycle.
- clr_in/set_in in the same cycle as a winning req: no grant and no ptr advance. The requester keeps req high and wins on a later IDLE cycle.
- data_in is sampled only at the grant edge. Changes at any other time have no effect.

## Test plan
N_REQ=4, WIDTH=8, HOLD_CYC=2 unless noted.
- Async reset: after loading 0x3C, assert reset_ah_in between edges. Required: q_out=0x00, valid_out=0, busy_out=0, grant_out=0000 before the next edge.
- Single load: in IDLE drive req=0010 with data[1]=0xA5. Required at the next edge: q_out=0xA5, grant_out=0010 for one cycle, owner_out=1, valid_out=1. busy_out is high 2 cycles, then low.
- Round robin: hold req=1111 from reset. Required: grants 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart. q_out tracks each winner's data word.
- Wrap and skip: after a grant to index 2 (ptr=3), drive req=0001. Required: grant_out=0001 at the next IDLE edge and ptr=1.
- Clear mid-HOLD: pulse clr_in one cycle after a load of 0x77. Required: q_out=0x00, valid_out=0, busy_out=0 next cycle. A pending req is granted on the following edge.
- Set vs clear vs req: in IDLE drive set_in=1 with req=0100. Required: q_out=0xFF, valid_out=1, no grant, owner unchanged. Then drive clr_in=1 and set_in=1 together. Required: q_out=0x00, valid_out=0.
